fifo_pack_reader: RTL
=====================

Name: fifo_pack_reader

Overview:
- Read-side sequencer for the FIFO buffer and controller pair in the data-width-conversion path.
- Pops RATIO narrow words from a first-word-fall-through FIFO and packs them into one wide word.
- Presents the wide word downstream on a valid/ready handshake.
- Owns the FIFO read strobe; the FIFO's empty flag and combinational read data are its only inputs from the buffer.

Parameters:
- DATA_WIDTH, 8: width of one FIFO entry.
- RATIO, 2: narrow words per wide word; legal values 2 to 8.
- MSB_FIRST, 0: 0 = first popped word lands in bits [DATA_WIDTH-1:0]; 1 = first popped word lands in the top slice.

Ports:
- clk_i  in  1  single system clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rd_data_i  in  DATA_WIDTH  FIFO data at the current read address; valid whenever fifo_empty_i=0.
- fifo_read_o  out  1  pop strobe to the FIFO read input.
- flush_i  in  1  emit the partially filled word now.
- wide_data_o  out  DATA_WIDTH*RATIO  packed word.
- wide_count_o  out  $clog2(RATIO+1)  number of valid slices in wide_data_o.
- wide_valid_o  out  1  wide word available.
- wide_ready_i  in  1  downstream accepts the wide word.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - Reset values: state=COLLECT, slice counter=0, wide_data_o=0, wide_count_o=0, wide_valid_o=0.
  - fifo_read_o is forced to 0 while reset_i=1.
  - Reset asserted mid-word discards the collected slices; no partial word is emitted.
- State COLLECT:
  - fifo_read_o = ~fifo_empty_i (combinational); a pop takes effect at the same clock edge.
  - On each pop, fifo_rd_data_i is written into slice index cnt, or RATIO-1-cnt when MSB_FIRST=1, and cnt increments.
  - When a pop occurs with cnt==RATIO-1:
    - go to HOLD; wide_valid_o=1 and wide_count_o=RATIO in the next cycle;
    - cnt returns to 0.
  - Latency: wide_valid_o rises 1 cycle after the edge that pops the last slice.
- Flush:
  - flush_i=1 in COLLECT with cnt>0 and no pop: go to HOLD with wide_count_o=cnt. Unfilled slices read as 0.
  - flush_i=1 with a pop in the same cycle: the popped word is captured first, then the flush applies with count cnt+1. If cnt+1==RATIO this is a normal full word.
  - flush_i=1 with cnt==0 and no pop: ignored.
  - flush_i in HOLD: ignored.
- State HOLD:
  - fifo_read_o=0.
  - wide_data_o, wide_count_o and wide_valid_o stay stable until accepted.
  - wide_ready_i=1 completes the transfer at that edge. Next cycle: state=COLLECT, wide_valid_o=0, wide_count_o=0, data slices cleared to 0.
  - No pop occurs in the accept cycle, so sustained throughput is 1 wide word per RATIO+1 cycles.
- wide_ready_i in COLLECT: don't-care.
- FIFO empty mid-word: the block waits in COLLECT with cnt held; no timeout.
- Pop protection: fifo_read_o is never asserted while fifo_empty_i=1, so the FIFO sees no underflow pops.
- Arithmetic: cnt is $clog2(RATIO) bits wide and never exceeds RATIO-1.

Test Plan (DATA_WIDTH=8, RATIO=2, MSB_FIRST=0 unless stated):
- Reset release, then hold reset high -> all outputs 0; fifo_read_o=0 even with fifo_empty_i=0 during reset.
- FIFO holds 0x11 then 0x22, wide_ready_i=1 -> pops on 2 consecutive cycles; next cycle wide_data_o=0x2211, wide_count_o=2, valid for 1 cycle; third entry popped 1 cycle later.
- MSB_FIRST=1, same data -> wide_data_o=0x1122.
- wide_ready_i=0 for 5 cycles after valid with FIFO non-empty -> fifo_read_o=0 and wide_data_o stable throughout; accepted on the cycle ready rises; collection resumes the next cycle.
- Pop 0xAB, FIFO goes empty, flush_i pulse -> wide_data_o=0x00AB, wide_count_o=1. flush_i with cnt=0 -> no valid.
- Pop 0x11, then assert reset_i asynchronously between edges; release and pop 0x33, 0x44 -> wide_valid_o drops immediately on reset; the first word after release is 0x4433 (0x11 discarded).

Source files
------------

// File: rtl/fifo_pack_reader.sv
// fifo_pack_reader: pops RATIO narrow words from a first-word-fall-through
// FIFO, packs them into one wide word and offers it downstream on a
// valid/ready handshake.
//
// Handshake: wide_valid_o is raised when a word is complete (or flushed) and
// then wide_data_o, wide_count_o and wide_valid_o hold steady until a clock
// edge sees wide_valid_o=1 and wide_ready_i=1; that edge is the transfer.
// On the FIFO side, fifo_read_o is a same-cycle pop that is only asserted
// while the FIFO reports non-empty, so every asserted pop consumes exactly
// the word shown on fifo_rd_data_i at that edge.
module fifo_pack_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 2,
    parameter int MSB_FIRST  = 0
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          fifo_empty_i,
    input  logic [DATA_WIDTH-1:0]         fifo_rd_data_i,
    output logic                          fifo_read_o,
    input  logic                          flush_i,
    output logic [DATA_WIDTH*RATIO-1:0]   wide_data_o,
    output logic [$clog2(RATIO+1)-1:0]    wide_count_o,
    output logic                          wide_valid_o,
    input  logic                          wide_ready_i
);

    localparam int CW = $clog2(RATIO);
    localparam int NW = $clog2(RATIO+1);
    localparam int WW = DATA_WIDTH * RATIO;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   data_q, data_d;
    logic [NW-1:0]   count_q, count_d;
    logic            valid_q, valid_d;

    logic            pop;
    logic            last_slice;
    logic [CW-1:0]   slice_idx;

    // Pop only while collecting, only when the FIFO has data, never in reset.
    assign fifo_read_o = (state_q == COLLECT) && !fifo_empty_i && !reset_i;
    assign pop         = fifo_read_o;

    // Slot for the word popped this cycle; MSB_FIRST fills from the top down.
    assign slice_idx  = (MSB_FIRST != 0) ? (CW'(RATIO-1) - cnt_q) : cnt_q;
    assign last_slice = (cnt_q == CW'(RATIO-1));

    assign wide_data_o  = data_q;
    assign wide_count_o = count_q;
    assign wide_valid_o = valid_q;

    // Next-state and datapath decisions for both states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        count_d = count_q;
        valid_d = valid_q;
        case (state_q)
            COLLECT: begin
                if (pop) begin
                    for (int i = 0; i < RATIO; i++) begin
                        if (CW'(i) == slice_idx) begin
                            data_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data_i;
                        end
                    end
                    // A flush in the same cycle as a pop includes the popped word.
                    if (last_slice || flush_i) begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                        count_d = NW'(cnt_q) + NW'(1);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (flush_i && (cnt_q != '0)) begin
                    // Partial word: unfilled slices are still zero from the last clear.
                    state_d = HOLD;
                    valid_d = 1'b1;
                    count_d = NW'(cnt_q);
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (wide_ready_i) begin
                    state_d = COLLECT;
                    valid_d = 1'b0;
                    count_d = '0;
                    data_d  = '0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Slice counter and output word registers; reset discards any partial word.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

endmodule
